// File: rtl/ram_1w2r_tile_ctrl.sv
// Ping-pong tile controller for a 1W/2R RAM: fills one bank from a valid/ready producer while streaming the other as word pairs.
// Latency: last write at T gives rd_valid at T+3; rd_ready low holds the displayed pair, wr_ready low while the target bank is full.
module ram_1w2r_tile_ctrl #(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int PASS_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [PASS_W-1:0]        cfg_passes,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic [$clog2(DEPTH)-1:0] ram_read_addr0,
    output logic [$clog2(DEPTH)-1:0] ram_read_addr1,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_last,
    output logic                     rd_done,
    output logic                     busy
);

    localparam int AW         = $clog2(DEPTH);
    localparam int OW         = AW - 1;
    localparam int TILE_WORDS = DEPTH / 2;
    localparam logic [OW-1:0] LAST_PAIR_OFF = OW'(TILE_WORDS - 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              wr_bank;
    logic [1:0]        full;
    logic [OW-1:0]     wr_cnt;
    logic              rd_bank;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] pass;
    logic [OW-1:0]     iss_off;
    logic              iss_pend;
    logic [AW-1:0]     disp_addr;

    logic          adv;
    logic          issue;
    logic          iss_last_pair;
    logic          iss_last_pass;
    logic          tile_done;
    logic [AW-1:0] issue_addr;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;

    assign wr_ready       = !full[wr_bank];
    assign ram_we         = wr_valid & wr_ready;
    assign ram_write_addr = {wr_bank, wr_cnt};
    assign ram_din        = wr_data;

    assign adv           = !rd_valid | rd_ready;
    assign issue         = (state == RUN) & iss_pend & adv;
    assign iss_last_pair = (iss_off == LAST_PAIR_OFF);
    assign iss_last_pass = (pass == passes_q - PASS_W'(1));
    assign tile_done     = rd_valid & rd_ready & rd_done;
    assign issue_addr    = {rd_bank, iss_off};

    // While stalled, re-present the displayed pair's address so dout stays stable.
    assign ram_read_addr0 = adv ? issue_addr : disp_addr;
    assign ram_read_addr1 = {ram_read_addr0[AW-1:1], 1'b1};

    // Writer and reader always own different banks, so both flags can move in one cycle.
    assign full_set = (ram_we && (&wr_cnt)) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = tile_done ? (2'b01 << rd_bank) : 2'b00;

    assign busy = (|full) | (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_bank   <= 1'b0;
            full      <= 2'b00;
            wr_cnt    <= '0;
            rd_bank   <= 1'b0;
            passes_q  <= '0;
            pass      <= '0;
            iss_off   <= '0;
            iss_pend  <= 1'b0;
            disp_addr <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;

            if (ram_we) begin
                wr_cnt <= wr_cnt + OW'(1);
                if (&wr_cnt) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (adv) begin
                rd_valid <= issue;
                rd_last  <= issue & iss_last_pair;
                rd_done  <= issue & iss_last_pair & iss_last_pass;
                if (issue) begin
                    disp_addr <= issue_addr;
                end
            end

            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state    <= RUN;
                        passes_q <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                        pass     <= '0;
                        iss_off  <= '0;
                        iss_pend <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (iss_last_pair) begin
                            iss_off <= '0;
                            if (iss_last_pass) begin
                                iss_pend <= 1'b0;
                            end else begin
                                pass <= pass + PASS_W'(1);
                            end
                        end else begin
                            iss_off <= iss_off + OW'(2);
                        end
                    end
                    if (tile_done) begin
                        state   <= IDLE;
                        rd_bank <= ~rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_1w2r_tile_ctrl.sv
// Bench for ram_1w2r_tile_ctrl at DEPTH=16: cycle table for the basic tile, hand sequences for stall, overflow, passes and reset.
module tb_ram_1w2r_tile_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [7:0]  cfg_passes;
    logic        ram_we;
    logic [3:0]  ram_write_addr;
    logic [15:0] ram_din;
    logic [3:0]  ram_read_addr0;
    logic [3:0]  ram_read_addr1;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic        rd_done;
    logic        busy;

    ram_1w2r_tile_ctrl #(.DATA_WIDTH(16), .DEPTH(16), .PASS_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .cfg_passes(cfg_passes),
        .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_din(ram_din),
        .ram_read_addr0(ram_read_addr0), .ram_read_addr1(ram_read_addr1),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .rd_done(rd_done),
        .busy(busy)
    );

    // Synchronous-read RAM the controller drives.
    logic [15:0] mem [16];
    logic [15:0] dout0, dout1;
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_din;
        dout0 <= mem[ram_read_addr0];
        dout1 <= mem[ram_read_addr1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wv;
        bit e_wrdy;
        bit e_we;
        int e_wa;
        bit e_rv;
        bit e_last;
        bit e_done;
        bit e_busy;
        int e_ra;
        int e_d0;
    } vec_t;

    vec_t vecs[15];
    int n_vec = 0;
    int n_bad = 0;
    int sent;
    int first_hs, last_hs;
    bit ended;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    function automatic vec_t mk(bit wv, bit wrdy, bit we, int wa, bit rv, bit last, bit done,
                                bit bsy, int ra, int d0);
        vec_t v;
        v.wv = wv; v.e_wrdy = wrdy; v.e_we = we; v.e_wa = wa; v.e_rv = rv;
        v.e_last = last; v.e_done = done; v.e_busy = bsy; v.e_ra = ra; v.e_d0 = d0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    task automatic step();
        if (rd_valid && rd_ready) got_q.push_back({30'b0, dout0, dout1, rd_last, rd_done});
        @(negedge clk);
    endtask

    task automatic exp_pair(input logic [15:0] d0, input bit last, input bit done);
        logic [15:0] d1;
        d1 = d0 + 16'd1;
        exp_q.push_back({30'b0, d0, d1, last, done});
    endtask

    task automatic check_stream(input string name);
        chk({name, "_pairs"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_pair"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        #1;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_last", 64'(rd_last), 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_waddr", 64'(ram_write_addr), 64'd0);
        chk("rst_raddr0", 64'(ram_read_addr0), 64'd0);
    endtask

    // Write nw words from dbase with rd_ready high, until the controller goes idle.
    task automatic stream(input string name, input int nw, input logic [15:0] dbase,
                          input int wa0, input int budget);
        int cnt = 0;
        int cyc = 0;
        first_hs = -1;
        last_hs = -1;
        ended = 1'b0;
        while (cyc < budget && !ended) begin
            wr_valid = (cnt < nw);
            wr_data = dbase + 16'(cnt);
            rd_ready = 1'b1;
            #1;
            if (wr_valid && wr_ready) begin
                chk({name, "_waddr"}, 64'(ram_write_addr), 64'((wa0 + cnt) % 16));
                cnt++;
            end
            if (rd_valid && rd_ready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            step();
            cyc++;
            if (cnt == nw && !busy) ended = 1'b1;
        end
        wr_valid = 1'b0;
        if (!ended) timeout(name);
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, -1, -1);
        vecs[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0, -1, -1);
        vecs[2]  = mk(1, 1, 1, 2, 0, 0, 0, 0, -1, -1);
        vecs[3]  = mk(1, 1, 1, 3, 0, 0, 0, 0, -1, -1);
        vecs[4]  = mk(1, 1, 1, 4, 0, 0, 0, 0, -1, -1);
        vecs[5]  = mk(1, 1, 1, 5, 0, 0, 0, 0, -1, -1);
        vecs[6]  = mk(1, 1, 1, 6, 0, 0, 0, 0, -1, -1);
        vecs[7]  = mk(1, 1, 1, 7, 0, 0, 0, 0, -1, -1);
        vecs[8]  = mk(0, 1, 0, 8, 0, 0, 0, 1, -1, -1);
        vecs[9]  = mk(0, 1, 0, 8, 0, 0, 0, 1,  0, -1);
        vecs[10] = mk(0, 1, 0, 8, 1, 0, 0, 1,  2, 'h100);
        vecs[11] = mk(0, 1, 0, 8, 1, 0, 0, 1,  4, 'h102);
        vecs[12] = mk(0, 1, 0, 8, 1, 0, 0, 1,  6, 'h104);
        vecs[13] = mk(0, 1, 0, 8, 1, 1, 1, 1, -1, 'h106);
        vecs[14] = mk(0, 1, 0, 8, 0, 0, 0, 0, -1, -1);

        cfg_passes = 8'd1;

        // Basic tile, one pass, consumer always ready.
        reset_dut();
        for (int c = 0; c < 15; c++) begin
            wr_valid = vecs[c].wv;
            wr_data = 16'h100 + 16'(c);
            rd_ready = 1'b1;
            #1;
            chk("t1_wr_ready", 64'(wr_ready), 64'(vecs[c].e_wrdy));
            chk("t1_ram_we", 64'(ram_we), 64'(vecs[c].e_we));
            chk("t1_waddr", 64'(ram_write_addr), 64'(vecs[c].e_wa));
            chk("t1_rd_valid", 64'(rd_valid), 64'(vecs[c].e_rv));
            chk("t1_rd_last", 64'(rd_last), 64'(vecs[c].e_last));
            chk("t1_rd_done", 64'(rd_done), 64'(vecs[c].e_done));
            chk("t1_busy", 64'(busy), 64'(vecs[c].e_busy));
            if (vecs[c].e_ra >= 0) chk("t1_raddr0", 64'(ram_read_addr0), 64'(vecs[c].e_ra));
            if (vecs[c].e_d0 >= 0) begin
                chk("t1_dout0", 64'(dout0), 64'(vecs[c].e_d0));
                chk("t1_dout1", 64'(dout1), 64'(vecs[c].e_d0 + 1));
            end
            step();
        end
        got_q.delete();

        // Consumer ready pattern 1,0,0,1: displayed pair and its address hold while stalled.
        reset_dut();
        sent = 0;
        ended = 1'b0;
        for (int c = 0; c < 60 && !ended; c++) begin
            wr_valid = (sent < 8);
            wr_data = 16'h200 + 16'(sent);
            rd_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (wr_valid && wr_ready) sent++;
            if (rd_valid && !rd_ready) begin
                chk("t2_stall_raddr0", 64'(ram_read_addr0), 64'(2 * got_q.size()));
                chk("t2_stall_dout0", 64'(dout0), 64'(16'h200 + 16'(2 * got_q.size())));
                chk("t2_stall_last", 64'(rd_last), 64'(got_q.size() == 3));
            end
            step();
            if (sent == 8 && !busy) ended = 1'b1;
        end
        wr_valid = 1'b0;
        if (!ended) timeout("t2_drain");
        for (int k = 0; k < 4; k++) exp_pair(16'h200 + 16'(2 * k), k == 3, k == 3);
        check_stream("t2");

        // 24 words with the consumer stalled: both banks fill, then bank 0 is refilled.
        reset_dut();
        sent = 0;
        ended = 1'b0;
        for (int c = 0; c < 80 && !ended; c++) begin
            wr_valid = (sent < 24);
            wr_data = 16'h300 + 16'(sent);
            rd_ready = (c >= 20);
            #1;
            if (c == 15) chk("t3_wr_ready_c15", 64'(wr_ready), 64'd1);
            if (c == 16) chk("t3_wr_ready_full", 64'(wr_ready), 64'd0);
            if (c == 23) chk("t3_wr_ready_done_cycle", 64'(wr_ready), 64'd0);
            if (c == 24) chk("t3_wr_ready_freed", 64'(wr_ready), 64'd1);
            if (wr_valid && wr_ready) begin
                if (sent >= 16) chk("t3_refill_waddr", 64'(ram_write_addr), 64'(sent - 16));
                sent++;
            end
            step();
            if (sent == 24 && !busy) ended = 1'b1;
        end
        wr_valid = 1'b0;
        if (!ended) timeout("t3_drain");
        for (int k = 0; k < 12; k++) exp_pair(16'h300 + 16'(2 * k), k % 4 == 3, k % 4 == 3);
        check_stream("t3");

        // Three passes over one tile, gap-free.
        reset_dut();
        cfg_passes = 8'd3;
        stream("t4", 8, 16'h400, 0, 60);
        chk("t4_gapfree", 64'(last_hs - first_hs), 64'd11);
        for (int j = 0; j < 12; j++) exp_pair(16'h400 + 16'(2 * (j % 4)), j % 4 == 3, j == 11);
        check_stream("t4");

        // Zero passes behaves as one.
        reset_dut();
        cfg_passes = 8'd0;
        stream("t5", 8, 16'h500, 0, 60);
        chk("t5_gapfree", 64'(last_hs - first_hs), 64'd3);
        for (int k = 0; k < 4; k++) exp_pair(16'h500 + 16'(2 * k), k == 3, k == 3);
        check_stream("t5");

        // Reset after two pairs, then a fresh tile.
        reset_dut();
        cfg_passes = 8'd1;
        sent = 0;
        ended = 1'b0;
        for (int c = 0; c < 40 && !ended; c++) begin
            wr_valid = (sent < 8);
            wr_data = 16'h600 + 16'(sent);
            rd_ready = 1'b1;
            #1;
            if (wr_valid && wr_ready) sent++;
            step();
            if (got_q.size() == 2) ended = 1'b1;
        end
        if (!ended) timeout("t6_two_pairs");
        rst = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rd_valid", 64'(rd_valid), 64'd0);
        chk("t6_wr_ready", 64'(wr_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_waddr", 64'(ram_write_addr), 64'd0);
        got_q.delete();
        stream("t6", 8, 16'h700, 0, 60);
        for (int k = 0; k < 4; k++) exp_pair(16'h700 + 16'(2 * k), k == 3, k == 3);
        check_stream("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
